// File: rtl/l2p_multi_if.sv
// Bundle of per-channel level inputs, controls and pulse outputs for l2p_multi.
// The master side drives levels/mode/clear; the slave side (the converter) drives results.
interface l2p_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   d;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   ovr_clr;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   level;
  logic [CH-1:0]   ovr;
  logic            any_pulse;

  modport master (
    output d, mode, ovr_clr,
    input  pulse, level, ovr, any_pulse
  );

  modport slave (
    input  d, mode, ovr_clr,
    output pulse, level, ovr, any_pulse
  );
endinterface

// File: rtl/l2p_multi.sv
// Multi-channel level-to-pulse converter.
// Each channel: optional synchroniser chain -> edge history -> edge select ->
// stretch counter producing a registered pulse, plus a sticky overrun flag that
// records an edge arriving while the channel's pulse is already high.
module l2p_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  l2p_multi_if.slave   bus
);

  localparam int RW = $clog2(STRETCH + 1);
  localparam logic [RW-1:0] RELOAD  = RW'(STRETCH - 1);
  localparam logic [RW-1:0] REM_ONE = RW'(1);
  localparam logic [RW-1:0] REM_ZERO = RW'(0);

  logic [CH-1:0] lvl_s;
  logic [CH-1:0] prev_q;
  logic [CH-1:0] rise_s;
  logic [CH-1:0] fall_s;
  logic [CH-1:0] ev_s;
  logic [CH-1:0] pulse_q;
  logic [CH-1:0] pulse_d;
  logic [CH-1:0] ovr_q;
  logic [CH-1:0] ovr_d;
  logic [RW-1:0] rem_q [CH];
  logic [RW-1:0] rem_d [CH];
  logic          any_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // Inputs are already in the clk domain: use them directly.
      assign lvl_s = bus.d;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];

      // Synchroniser shift chain, all channels in parallel.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          sync_q[0] <= bus.d;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign lvl_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detection, edge selection and next-state for pulse, counter and overrun.
  always_comb begin
    rise_s  = lvl_s & ~prev_q;
    fall_s  = ~lvl_s & prev_q;
    ev_s    = '0;
    pulse_d = '0;
    ovr_d   = '0;
    for (int i = 0; i < CH; i++) begin
      rem_d[i] = rem_q[i];
      case (bus.mode[2*i +: 2])
        2'b00:   ev_s[i] = rise_s[i];
        2'b01:   ev_s[i] = fall_s[i];
        2'b10:   ev_s[i] = rise_s[i] | fall_s[i];
        default: ev_s[i] = 1'b0;
      endcase

      if (ev_s[i]) begin
        pulse_d[i] = 1'b1;
        rem_d[i]   = RELOAD;
      end else if (rem_q[i] != REM_ZERO) begin
        pulse_d[i] = 1'b1;
        rem_d[i]   = rem_q[i] - REM_ONE;
      end else begin
        pulse_d[i] = 1'b0;
        rem_d[i]   = rem_q[i];
      end

      // An edge landing on a live pulse is an overrun; setting beats clearing.
      if (ev_s[i] && pulse_q[i]) begin
        ovr_d[i] = 1'b1;
      end else if (bus.ovr_clr[i]) begin
        ovr_d[i] = 1'b0;
      end else begin
        ovr_d[i] = ovr_q[i];
      end
    end
  end

  // State registers: edge history tracks the level in every mode so enabling never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      pulse_q <= '0;
      ovr_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        rem_q[i] <= '0;
      end
    end else begin
      prev_q  <= lvl_s;
      pulse_q <= pulse_d;
      ovr_q   <= ovr_d;
      any_q   <= |pulse_d;
      for (int i = 0; i < CH; i++) begin
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.level     = lvl_s;
  assign bus.ovr       = ovr_q;
  assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_l2p_multi.sv
// Scoreboard bench for l2p_multi using three parameterisations side by side.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// i.e. half a cycle after the rising edge that produced them.
module tb_l2p_multi;

  logic clk;
  logic reset_n;

  l2p_multi_if #(.CH(4)) ifa ();
  l2p_multi_if #(.CH(4)) ifb ();
  l2p_multi_if #(.CH(4)) ifc ();

  l2p_multi #(.CH(4), .SYNC_STAGES(2), .STRETCH(1)) u_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  l2p_multi #(.CH(4), .SYNC_STAGES(0), .STRETCH(5)) u_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
  l2p_multi #(.CH(4), .SYNC_STAGES(2), .STRETCH(8)) u_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

  typedef struct packed {
    logic [3:0] pulse;
    logic       any;
    logic [3:0] ovr;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    n_checks++;
    if ({ifa.pulse, ifb.pulse, ifc.pulse} !== 12'h000) begin
      n_fail++; $display("FAIL reset_pulse: got %h required 000", {ifa.pulse, ifb.pulse, ifc.pulse});
    end
    n_checks++;
    if ({ifa.ovr, ifb.ovr, ifc.ovr} !== 12'h000) begin
      n_fail++; $display("FAIL reset_ovr: got %h required 000", {ifa.ovr, ifb.ovr, ifc.ovr});
    end
    n_checks++;
    if ({ifa.any_pulse, ifb.any_pulse, ifc.any_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_any: got %b required 000", {ifa.any_pulse, ifb.any_pulse, ifc.any_pulse});
    end
    n_checks++;
    if ({ifa.level, ifc.level} !== 8'h00) begin
      n_fail++; $display("FAIL reset_level: got %h required 00", {ifa.level, ifc.level});
    end
  endtask

  // Single rise on channel 0 through two sync stages, STRETCH=1.
  task automatic test_basic();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      e.pulse = (c == 2) ? 4'b0001 : 4'b0000;
      e.any   = (c == 2) ? 1'b1 : 1'b0;
      e.ovr   = 4'b0000;
      exp_q.push_back(e);
    end
    ifa.d = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifa.pulse !== e.pulse) begin
        n_fail++; $display("FAIL basic_pulse c=%0d: got %b required %b", c, ifa.pulse, e.pulse);
      end
      n_checks++;
      if (ifa.any_pulse !== e.any) begin
        n_fail++; $display("FAIL basic_any c=%0d: got %b required %b", c, ifa.any_pulse, e.any);
      end
      n_checks++;
      if (ifa.ovr !== e.ovr) begin
        n_fail++; $display("FAIL basic_ovr c=%0d: got %b required %b", c, ifa.ovr, e.ovr);
      end
      if (c < 2) begin
        n_checks++;
        if (ifa.level[0] !== ((c == 1) ? 1'b1 : 1'b0)) begin
          n_fail++; $display("FAIL basic_level c=%0d: got %b", c, ifa.level[0]);
        end
      end
    end
  endtask

  // Channel 1 toggled 0->1->0 under each edge-select mode.
  task automatic test_mode_sweep();
    exp_t       e;
    logic [1:0] m2;
    for (int m = 0; m < 4; m++) begin
      m2 = m[1:0];
      ifa.mode[3:2] = m2;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        e.pulse = 4'b0000;
        if (c == 2  && (m2 == 2'b00 || m2 == 2'b10)) e.pulse = 4'b0010;
        if (c == 12 && (m2 == 2'b01 || m2 == 2'b10)) e.pulse = 4'b0010;
        e.any = |e.pulse;
        e.ovr = 4'b0000;
        exp_q.push_back(e);
      end
      for (int c = 0; c < 20; c++) begin
        if (c == 0)  ifa.d[1] = 1'b1;
        if (c == 10) ifa.d[1] = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (ifa.pulse !== e.pulse || ifa.any_pulse !== e.any || ifa.ovr !== e.ovr) begin
          n_fail++;
          $display("FAIL mode_sweep m=%0d c=%0d: got p=%b a=%b o=%b required p=%b a=%b o=%b",
                   m, c, ifa.pulse, ifa.any_pulse, ifa.ovr, e.pulse, e.any, e.ovr);
        end
      end
    end
    ifa.mode[3:2] = 2'b00;
  endtask

  // Channel 2 goes high while disabled, then is enabled: no pulse may appear.
  task automatic test_enable_steady();
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      e.pulse = 4'b0000; e.any = 1'b0; e.ovr = 4'b0000;
      exp_q.push_back(e);
    end
    ifa.mode[5:4] = 2'b11;
    ifa.d[2] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) ifa.mode[5:4] = 2'b00;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifa.pulse !== e.pulse || ifa.any_pulse !== e.any) begin
        n_fail++; $display("FAIL enable_steady c=%0d: got p=%b a=%b required p=%b a=%b",
                           c, ifa.pulse, ifa.any_pulse, e.pulse, e.any);
      end
    end
  endtask

  // No synchroniser, STRETCH=5: one rise on channel 2 gives five pulse cycles.
  task automatic test_stretch();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      e.pulse = (c < 5) ? 4'b0100 : 4'b0000;
      e.any   = (c < 5) ? 1'b1 : 1'b0;
      e.ovr   = 4'b0000;
      exp_q.push_back(e);
    end
    ifb.d[2] = 1'b1;
    #1;
    n_checks++;
    if (ifb.level[2] !== 1'b1) begin
      n_fail++; $display("FAIL stretch_level_bypass: got %b required 1", ifb.level[2]);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifb.pulse !== e.pulse) begin
        n_fail++; $display("FAIL stretch_pulse c=%0d: got %b required %b", c, ifb.pulse, e.pulse);
      end
      n_checks++;
      if (ifb.any_pulse !== e.any) begin
        n_fail++; $display("FAIL stretch_any c=%0d: got %b required %b", c, ifb.any_pulse, e.any);
      end
    end
  endtask

  // Retrigger on channel 3 while stretched, then set-vs-clear and clear alone.
  task automatic test_retrigger();
    exp_t e;
    for (int c = 0; c < 10; c++) begin
      e.pulse = (c < 8) ? 4'b1000 : 4'b0000;
      e.any   = (c < 8) ? 1'b1 : 1'b0;
      e.ovr   = (c >= 3) ? 4'b1000 : 4'b0000;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 0) ifb.d[3] = 1'b1;
      if (c == 1) ifb.d[3] = 1'b0;
      if (c == 3) ifb.d[3] = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifb.pulse !== e.pulse || ifb.any_pulse !== e.any) begin
        n_fail++; $display("FAIL retrig_pulse c=%0d: got p=%b a=%b required p=%b a=%b",
                           c, ifb.pulse, ifb.any_pulse, e.pulse, e.any);
      end
      n_checks++;
      if (ifb.ovr !== e.ovr) begin
        n_fail++; $display("FAIL retrig_ovr c=%0d: got %b required %b", c, ifb.ovr, e.ovr);
      end
    end
    for (int c = 0; c < 13; c++) begin
      e.pulse = (c >= 1 && c <= 7) ? 4'b1000 : 4'b0000;
      e.any   = |e.pulse;
      e.ovr   = (c < 10) ? 4'b1000 : 4'b0000;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 13; c++) begin
      if (c == 0)  ifb.d[3] = 1'b0;
      if (c == 1)  ifb.d[3] = 1'b1;
      if (c == 2)  ifb.d[3] = 1'b0;
      if (c == 3)  begin ifb.d[3] = 1'b1; ifb.ovr_clr[3] = 1'b1; end
      if (c == 4)  ifb.ovr_clr[3] = 1'b0;
      if (c == 10) ifb.ovr_clr[3] = 1'b1;
      if (c == 11) ifb.ovr_clr[3] = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifb.pulse !== e.pulse || ifb.any_pulse !== e.any) begin
        n_fail++; $display("FAIL clr_pulse c=%0d: got p=%b a=%b required p=%b a=%b",
                           c, ifb.pulse, ifb.any_pulse, e.pulse, e.any);
      end
      n_checks++;
      if (ifb.ovr !== e.ovr) begin
        n_fail++; $display("FAIL clr_ovr c=%0d: got %b required %b", c, ifb.ovr, e.ovr);
      end
    end
  endtask

  // STRETCH=8: reset during a pulse clears asynchronously; held-high level re-pulses after release.
  task automatic test_reset_midpulse();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      e.pulse = (c >= 2) ? 4'b0011 : 4'b0000;
      e.any   = (c >= 2) ? 1'b1 : 1'b0;
      e.ovr   = (c == 4) ? 4'b0010 : 4'b0000;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) ifc.d[1:0] = 2'b11;
      if (c == 1) ifc.d[1]   = 1'b0;
      if (c == 2) ifc.d[1]   = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifc.pulse !== e.pulse || ifc.any_pulse !== e.any || ifc.ovr !== e.ovr) begin
        n_fail++; $display("FAIL pre_reset c=%0d: got p=%b a=%b o=%b required p=%b a=%b o=%b",
                           c, ifc.pulse, ifc.any_pulse, ifc.ovr, e.pulse, e.any, e.ovr);
      end
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ifc.pulse !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_pulse: got %b required 0000", ifc.pulse);
    end
    n_checks++;
    if (ifc.ovr !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_ovr: got %b required 0000", ifc.ovr);
    end
    n_checks++;
    if (ifc.any_pulse !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_any: got %b required 0", ifc.any_pulse);
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      e.pulse = (c >= 2 && c <= 9) ? 4'b0011 : 4'b0000;
      e.any   = |e.pulse;
      e.ovr   = 4'b0000;
      exp_q.push_back(e);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ifc.pulse !== e.pulse || ifc.any_pulse !== e.any || ifc.ovr !== e.ovr) begin
        n_fail++; $display("FAIL post_release c=%0d: got p=%b a=%b o=%b required p=%b a=%b o=%b",
                           c, ifc.pulse, ifc.any_pulse, ifc.ovr, e.pulse, e.any, e.ovr);
      end
    end
  endtask

  // Test sequence.
  initial begin
    reset_n     = 1'b0;
    ifa.d       = 4'b0000; ifa.mode = 8'h00; ifa.ovr_clr = 4'b0000;
    ifb.d       = 4'b0000; ifb.mode = 8'h00; ifb.ovr_clr = 4'b0000;
    ifc.d       = 4'b0000; ifc.mode = 8'h00; ifc.ovr_clr = 4'b0000;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    test_basic();
    test_mode_sweep();
    test_enable_steady();
    test_stretch();
    test_retrigger();
    test_reset_midpulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2p_multi.md
Name: l2p_multi

Overview:
- Multi-channel, parametrised level-to-pulse converter.
- Each channel optionally synchronises an asynchronous level input, then detects a rising, falling or either edge as selected per channel.
- Each detected edge produces a registered output pulse stretched to a programmable width. Retriggers during a pulse are flagged as sticky overruns.
- Sits at clock-domain boundaries, where slow or foreign-domain level signals must become single events for local control logic.

Parameters:
- CH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (0..4). 0 bypasses synchronisation and is for inputs already in the clk domain.
- STRETCH, 1: output pulse width in clk cycles (1..255).

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous active-low reset; assertion is asynchronous.
- d  input  CH  level inputs, one bit per channel.
- mode  input  2*CH  per-channel edge select, bits [2i+1:2i] for channel i: 00 rising, 01 falling, 10 both, 11 disabled.
- ovr_clr  input  CH  synchronous per-channel clear of the overrun flag.
- pulse  output  CH  registered stretched pulse per channel.
- level  output  CH  synchronised level per channel (last sync stage, or d when SYNC_STAGES=0).
- ovr  output  CH  sticky overrun flag per channel.
- any_pulse  output  1  registered OR of all pulse bits; coincident with pulse.

Behaviour:
- Reset (reset_n=0): all sync flops, edge-history regs, stretch counters, pulse, ovr and any_pulse go to 0 immediately.
  - Consequence: if d is held high through reset release, a rising edge is seen after release, and a channel in rising or both mode pulses once. This is required behaviour.
- Per-channel datapath: s[1..N] shift chain, N=SYNC_STAGES. Synced level L = s[N] (or d if N=0). History reg P <= L every cycle, in all modes including disabled.
- Edge detect, combinational:
  - rise = L & ~P
  - fall = ~L & P
  - ev = rise (00), fall (01), rise|fall (10), 0 (11)
- Latency: d changes before clock edge E0; ev is true during the cycle after edge E(N-1); pulse goes 1 after edge E(N). This is N+1 edges, so 1 edge for N=0.
- Stretch counter rem, width clog2(STRETCH+1):
  - on ev: pulse<=1, rem<=STRETCH-1
  - else if rem!=0: rem<=rem-1, pulse stays 1
  - else: pulse<=0
  - Result: an isolated event gives exactly STRETCH cycles of pulse high.
- Retrigger: ev while pulse=1 and rem!=0 or pulse will otherwise stay high. Precisely: ev in any cycle where pulse=1.
  - Reloads rem to STRETCH-1; pulse stays continuously high, so there is no gap and no extra edge.
  - Sets ovr<=1.
  - With STRETCH=1, back-to-back events on consecutive cycles also count as overrun.
- ovr: sticky. Cleared by ovr_clr=1 on the next edge. Simultaneous set and clear: set wins.
- mode changes take effect on the next cycle's ev evaluation. Because P tracks L in all modes, enabling a channel never creates a spurious edge from old history. Changing to disabled does not truncate a pulse already in progress.
- any_pulse is registered from the next-state pulse vector, so it is cycle-aligned with pulse.
- Channels are fully independent; no shared state except any_pulse.
- mode values outside the encoding do not exist (2-bit full decode).

Test Plan:
- CH=4, SYNC_STAGES=2, STRETCH=1, mode=0 (all rising): d[0] 0→1 before edge E0 → pulse[0]=1 only between E2 and E3; level[0]=1 after E1; ovr=0.
- Mode sweep on channel 1, STRETCH=1, toggling d[1] 0→1→0 with 10-cycle spacing:
  - mode 00 → one pulse
  - mode 01 → one pulse on the fall
  - mode 10 → two pulses
  - mode 11 → none
- STRETCH=5, SYNC_STAGES=0: single rise on d[2] → pulse[2] high for exactly 5 cycles starting after the sampling edge; any_pulse identical.
- STRETCH=5: second rise 3 cycles after the first (d toggled 1→0→1) → pulse continuous for 3+5=8 cycles and ovr[3]=1. Assert ovr_clr[3] in the same cycle as a new retrigger → ovr stays 1. Clear alone later → ovr=0.
- Reset mid-pulse (STRETCH=8, reset_n low at cycle 3 of pulse) → pulse, ovr, any_pulse go 0 asynchronously before the next edge. With d held high across release and rising mode → one pulse after N+1 edges.
- Enable from disabled while d is steady high (mode 11→00) → no pulse generated.
